xgriscv_fetch: RTL and testbench

Instruction-fetch stage of the xgriscv pipelined core. Owns the architectural PC, drives the instruction-memory read address, and registers each fetched word into the IF/ID pipeline register consumed by decode. Honours stall and redirect (branch/jump flush) requests from later stages. Exports the PC that the top-level testbench monitors for end-of-program detection.

---
 rtl/xgriscv_fetch_pkg.sv | 24 ++
 rtl/xgriscv_ifid_reg.sv | 59 +++++
 rtl/xgriscv_fetch.sv | 122 ++++++++++++
 tb/tb_xgriscv_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// xgriscv_fetch_pkg
// Shared encodings for the xgriscv instruction-fetch slice: datapath widths,
// the bubble instruction placed into pipeline registers on flush, the ebreak
// word that stops fetch when XGRISCV_FETCH_HALT_EN is defined, and the
// default reset PC.
// ---------------------------------------------------------------------------
package xgriscv_fetch_pkg;

    localparam int ADDR_SIZE  = 32;
    localparam int INSTR_SIZE = 32;

    // addi x0,x0,0 : architecturally a no-op, used as the pipeline bubble
    localparam logic [INSTR_SIZE-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    // ebreak : fetch stops on this word when the halt feature is built in
    localparam logic [INSTR_SIZE-1:0] HALT_INSN = 32'h0010_0073;

    localparam logic [ADDR_SIZE-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned, so redirect targets drop these bits
    localparam logic [ADDR_SIZE-1:0] ADDR_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/xgriscv_ifid_reg.sv
// ---------------------------------------------------------------------------
// xgriscv_ifid_reg
// IF/ID pipeline register with load enable, flush and asynchronous
// active-high reset. Flush has priority over enable and loads a bubble
// (NOP, pc 0, valid 0). The same pattern serves the later pipeline
// registers.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active high
//   en_i      in   load pc_i/instr_i and mark the entry valid
//   flush_i   in   load a bubble (wins over en_i)
//   pc_i      in   PC of the instruction being captured
//   instr_i   in   instruction word being captured
//   pc_o      out  registered PC
//   instr_o   out  registered instruction
//   valid_o   out  entry holds a real instruction
// ---------------------------------------------------------------------------
module xgriscv_ifid_reg
    import xgriscv_fetch_pkg::*;
#(
    parameter logic [INSTR_SIZE-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [ADDR_SIZE-1:0]  pc_i,
    input  logic [INSTR_SIZE-1:0] instr_i,
    output logic [ADDR_SIZE-1:0]  pc_o,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic                  valid_o
);

    logic [ADDR_SIZE-1:0]  pc_q;
    logic [INSTR_SIZE-1:0] instr_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= '0;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/xgriscv_fetch.sv
// ---------------------------------------------------------------------------
// xgriscv_fetch
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// address and captures each fetched word into the IF/ID register. Each
// edge resolves redirect > stall > advance.
//
// Build option: XGRISCV_FETCH_HALT_EN
//   defined   - fetching the ebreak word captures it, then sets a sticky
//               halted flag that freezes pc/count and bubbles IF/ID,
//               ignoring stall and redirect until reset.
//   undefined - halted is tied low and ebreak is an ordinary word.
//
// Ports:
//   clk, rstn        clock and asynchronous active-high reset (rstn=1 resets)
//   stall            hold pc, IF/ID and fetch_count
//   redirect_valid   reload pc from redirect_pc (aligned) and bubble IF/ID
//   redirect_pc      redirect target
//   imem_addr        combinational copy of pc
//   imem_rdata       instruction word at imem_addr
//   pc               current fetch PC
//   id_pc/id_instr/id_valid   IF/ID register contents
//   fetch_count      instructions captured into IF/ID (wraps at 2^32)
//   halted           fetch stopped on ebreak
// ---------------------------------------------------------------------------
module xgriscv_fetch
    import xgriscv_fetch_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0]  PC_RESET = PC_RESET_DEFAULT,
    parameter logic [INSTR_SIZE-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    output logic [ADDR_SIZE-1:0]  pc,
    output logic [ADDR_SIZE-1:0]  id_pc,
    output logic [INSTR_SIZE-1:0] id_instr,
    output logic                  id_valid,
    output logic [31:0]           fetch_count,
    output logic                  halted
);

    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [31:0]          count_q, count_d;
    logic                 haltedNow;
    logic                 advance;
    logic                 flushIfid;

`ifdef XGRISCV_FETCH_HALT_EN
    logic halted_q, halted_d;

    // Sticky: set when the ebreak word is captured on an advance edge
    always_comb begin
        halted_d = halted_q;
        if (advance && (imem_rdata == HALT_INSN)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign haltedNow = halted_q;
`else
    assign haltedNow = 1'b0;
`endif

    // A halted stage ignores stall/redirect and keeps feeding bubbles
    assign advance   = !haltedNow && !redirect_valid && !stall;
    assign flushIfid = haltedNow || redirect_valid;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (haltedNow) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_ALIGN_MASK;
        end else if (!stall) begin
            pc_d    = pc_q + ADDR_SIZE'(4);
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc_q    <= PC_RESET;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    xgriscv_ifid_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_ifid (
        .clk     (clk),
        .rst     (rstn),
        .en_i    (advance),
        .flush_i (flushIfid),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .pc_o    (id_pc),
        .instr_o (id_instr),
        .valid_o (id_valid)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign fetch_count = count_q;
    assign halted      = haltedNow;

endmodule

// File: tb/tb_xgriscv_fetch.sv
// ---------------------------------------------------------------------------
// tb_xgriscv_fetch
// Self-checking bench for xgriscv_fetch. A behavioural model of the fetch
// stage tracks pc, the IF/ID contents, the fetch count and the halt flag;
// directed sequences cover reset, stall, redirect, PC wrap and an
// asynchronous reset in the middle of a cycle, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_xgriscv_fetch;
    import xgriscv_fetch_pkg::*;

`ifdef XGRISCV_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] fetch_count;
    logic        halted;

    bit          haltArmed = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] mPc, mIdPc, mIdInstr, mCount;
    logic        mIdValid, mHalted;

    xgriscv_fetch dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .fetch_count    (fetch_count),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address; the
    // ebreak word appears only at 0x1C and only when the halt test arms it
    function automatic logic [31:0] memWord(input logic [31:0] a, input bit armed);
        logic [31:0] w;
        if (armed && a == 32'h0000_001C) return HALT_INSN;
        w = (a * 32'h9E37_79B9) ^ 32'h1234_5678;
        if (w == HALT_INSN) w = w ^ 32'h0000_0100;
        return w;
    endfunction

    assign imem_rdata = memWord(imem_addr, haltArmed);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".pc"},        pc,               mPc);
        checkOutput({phase, ".imem_addr"}, imem_addr,        mPc);
        checkOutput({phase, ".id_pc"},     id_pc,            mIdPc);
        checkOutput({phase, ".id_instr"},  id_instr,         mIdInstr);
        checkOutput({phase, ".id_valid"},  {31'd0, id_valid}, {31'd0, mIdValid});
        checkOutput({phase, ".count"},     fetch_count,      mCount);
        checkOutput({phase, ".halted"},    {31'd0, halted},   {31'd0, mHalted});
    endtask

    task automatic modelReset();
        mPc = 32'h0; mIdPc = 32'h0; mIdInstr = 32'h0000_0013;
        mIdValid = 1'b0; mCount = 32'h0; mHalted = 1'b0;
    endtask

    // One clock edge of the fetch stage, from the rules of operation
    task automatic modelStep(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] w;
        if (mHalted) begin
            mIdPc = 0; mIdInstr = 32'h0000_0013; mIdValid = 1'b0;
        end else if (r) begin
            mPc = (rp / 4) * 4;
            mIdPc = 0; mIdInstr = 32'h0000_0013; mIdValid = 1'b0;
        end else if (!s) begin
            w = memWord(mPc, haltArmed);
            mIdPc = mPc; mIdInstr = w; mIdValid = 1'b1;
            mCount = mCount + 1;
            mPc = mPc + 4;
            if (HALT_EN && w == 32'h0010_0073) mHalted = 1'b1;
        end
    endtask

    // Drive one cycle's inputs at a falling edge, clock it, check after
    task automatic applyStimulus(input string phase, input logic s, input logic r, input logic [31:0] rp);
        stall = s; redirect_valid = r; redirect_pc = rp;
        @(posedge clk);
        modelStep(s, r, rp);
        @(negedge clk);
        checkAll(phase);
    endtask

    task automatic applyReset();
        rstn = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        modelReset();
        checkAll("reset");
        rstn = 1'b0;
    endtask

    initial begin
        rstn = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        modelReset();

        // Straight-line fetch of W0..W3
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus("seq", 1'b0, 1'b0, 32'h0);
        checkOutput("seq.count4", fetch_count, 32'd4);
        checkOutput("seq.pc10",   pc,          32'h0000_0010);
        checkOutput("seq.instrW3", id_instr,   memWord(32'h0000_000C, 1'b0));

        // Stall two cycles with pc at 8, then resume
        applyReset();
        applyStimulus("adv", 1'b0, 1'b0, 32'h0);
        applyStimulus("adv", 1'b0, 1'b0, 32'h0);
        applyStimulus("stall", 1'b1, 1'b0, 32'h0);
        applyStimulus("stall", 1'b1, 1'b0, 32'h0);
        checkOutput("stall.pc8",   pc,          32'h0000_0008);
        checkOutput("stall.idpc4", id_pc,       32'h0000_0004);
        checkOutput("stall.cnt2",  fetch_count, 32'd2);
        applyStimulus("resume", 1'b0, 1'b0, 32'h0);
        checkOutput("resume.idpc8", id_pc, 32'h0000_0008);

        // Redirect wins over a simultaneous stall; low bits are dropped
        applyStimulus("redir", 1'b1, 1'b1, 32'h0000_0042);
        checkOutput("redir.pc40",  pc,       32'h0000_0040);
        checkOutput("redir.valid", {31'd0, id_valid}, 32'd0);
        checkOutput("redir.nop",   id_instr, 32'h0000_0013);
        checkOutput("redir.cnt",   fetch_count, 32'd3);

        // Back-to-back redirects, then a redirect to the current pc
        applyStimulus("redir2", 1'b0, 1'b1, 32'h0000_0100);
        applyStimulus("redir2", 1'b0, 1'b1, 32'h0000_0203);
        applyStimulus("adv", 1'b0, 1'b0, 32'h0);
        applyStimulus("redirSelf", 1'b0, 1'b1, mPc);

        // PC wrap from the top of the address space
        applyStimulus("toTop", 1'b0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus("wrap", 1'b0, 1'b0, 32'h0);
        checkOutput("wrap.pc0",    pc,    32'h0000_0000);
        checkOutput("wrap.idpcTop", id_pc, 32'hFFFF_FFFC);

        // Asynchronous reset asserted mid-cycle while stalled at 0x10
        for (int i = 0; i < 4; i++) applyStimulus("adv", 1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        @(posedge clk);
        modelStep(1'b1, 1'b0, 32'h0);
        #2;
        rstn = 1'b1;
        #1;
        modelReset();
        checkAll("asyncRst");
        checkOutput("asyncRst.pc0", pc, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        applyStimulus("postRst", 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            applyStimulus("rand", s, r, rp);
        end

`ifdef XGRISCV_FETCH_HALT_EN
        // ebreak at 0x1C halts fetch; later redirect is ignored
        haltArmed = 1'b1;
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus("toHalt", 1'b0, 1'b0, 32'h0);
        checkOutput("halt.flag",  {31'd0, halted}, 32'd1);
        checkOutput("halt.pc20",  pc, 32'h0000_0020);
        checkOutput("halt.instr", id_instr, 32'h0010_0073);
        applyStimulus("halted", 1'b0, 1'b1, 32'h0000_0100);
        applyStimulus("halted", 1'b1, 1'b0, 32'h0);
        applyStimulus("halted", 1'b0, 1'b0, 32'h0);
        checkOutput("halted.pc20",  pc, 32'h0000_0020);
        checkOutput("halted.valid", {31'd0, id_valid}, 32'd0);
        checkOutput("halted.cnt8",  fetch_count, 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
